// File: rtl/bus_cmd_master_pkg.sv
// Shared definitions for the bus command master: command length width and
// the beat-counter terminal test.
package bus_cmd_master_pkg;

  // CMD_LEN carries (beats - 1), so 8 bits covers 1..256 beats.
  localparam int CMD_LEN_W = 8;

  // The beat counter holds the beats still owed after the current one.
  function automatic logic last_beat(input logic [CMD_LEN_W-1:0] beats_left);
    return (beats_left == '0);
  endfunction

endpackage

// File: rtl/bus_cmd_master.sv
// Bus command master: accepts single-write or burst-read commands on a
// valid/ready port, runs them on a strobed parallel bus and returns read
// beats on a valid/ready response port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a command, bus parked (address 0, strobes low)
// WRITE   | one-cycle BUS_WR pulse, bus data driven with latched data
// READ    | one-cycle BUS_RD pulse at the current beat address
// RD_WAIT | address held, responder drives data, captured at the exit edge
// RESP    | RSP_VALID high with stable data until the consumer accepts
module bus_cmd_master
  import bus_cmd_master_pkg::*;
#(
  parameter int ABUSWIDTH = 16,
  parameter int DBUSWIDTH = 8
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic                 CMD_VALID,
  output logic                 CMD_READY,
  input  logic                 CMD_WRITE,
  input  logic [ABUSWIDTH-1:0] CMD_ADD,
  input  logic [DBUSWIDTH-1:0] CMD_DATA,
  input  logic [CMD_LEN_W-1:0] CMD_LEN,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [DBUSWIDTH-1:0] RSP_DATA,
  output logic                 BUSY,
  output logic                 BUS_RD,
  output logic                 BUS_WR,
  output logic [ABUSWIDTH-1:0] BUS_ADD,
  inout  wire  [DBUSWIDTH-1:0] BUS_DATA
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    READ    = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [ABUSWIDTH-1:0]   add_q;
  logic [DBUSWIDTH-1:0]   data_q;
  logic [CMD_LEN_W-1:0]   len_q;
  logic [DBUSWIDTH-1:0]   rsp_data_q;
  logic                   cmd_hs;
  logic                   rsp_hs;

  assign cmd_hs = CMD_VALID & CMD_READY;
  assign rsp_hs = RSP_VALID & RSP_READY;

  // The only bus data driver: enabled solely while the write strobe is out.
  assign BUS_DATA = (state_q == WRITE) ? data_q : {DBUSWIDTH{1'bz}};

  assign RSP_DATA = rsp_data_q;

  // State register; reset parks the machine in IDLE immediately.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Command latch, beat counter/address stepping and read data capture.
  always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
    if (BUS_RST) begin
      add_q      <= '0;
      data_q     <= '0;
      len_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      if (cmd_hs) begin
        add_q  <= CMD_ADD;
        data_q <= CMD_DATA;
        len_q  <= CMD_LEN;
      end
      if (state_q == RD_WAIT) begin
        rsp_data_q <= BUS_DATA;
      end
      if (rsp_hs && !last_beat(len_q)) begin
        len_q <= len_q - 1'b1;
        add_q <= add_q + ABUSWIDTH'(1);
      end
    end
  end

  // Next-state decode and state-derived outputs; CMD_READY is held low
  // while reset is asserted even though the state already reads IDLE.
  always_comb begin
    state_d   = state_q;
    CMD_READY = 1'b0;
    BUSY      = 1'b1;
    BUS_RD    = 1'b0;
    BUS_WR    = 1'b0;
    BUS_ADD   = add_q;
    RSP_VALID = 1'b0;
    case (state_q)
      IDLE: begin
        CMD_READY = ~BUS_RST;
        BUSY      = 1'b0;
        BUS_ADD   = '0;
        if (CMD_VALID && !BUS_RST) state_d = CMD_WRITE ? WRITE : READ;
      end
      WRITE: begin
        BUS_WR  = 1'b1;
        state_d = IDLE;
      end
      READ: begin
        BUS_RD  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        state_d = RESP;
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_d = last_beat(len_q) ? IDLE : READ;
      end
      default: begin
        BUS_ADD = '0;
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_cmd_master.sv
// Directed bench for bus_cmd_master with a small bus memory responder.
module tb_bus_cmd_master;

  logic        bus_clk;
  logic        bus_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_add;
  logic [7:0]  cmd_data;
  logic [7:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        bus_rd;
  logic        bus_wr;
  logic [15:0] bus_add;
  wire  [7:0]  bus_data;

  int errors = 0;
  int checks = 0;

  bus_cmd_master #(.ABUSWIDTH(16), .DBUSWIDTH(8)) dut (
    .BUS_CLK   (bus_clk),
    .BUS_RST   (bus_rst),
    .CMD_VALID (cmd_valid),
    .CMD_READY (cmd_ready),
    .CMD_WRITE (cmd_write),
    .CMD_ADD   (cmd_add),
    .CMD_DATA  (cmd_data),
    .CMD_LEN   (cmd_len),
    .RSP_VALID (rsp_valid),
    .RSP_READY (rsp_ready),
    .RSP_DATA  (rsp_data),
    .BUSY      (busy),
    .BUS_RD    (bus_rd),
    .BUS_WR    (bus_wr),
    .BUS_ADD   (bus_add),
    .BUS_DATA  (bus_data)
  );

  initial bus_clk = 1'b0;
  always #5 bus_clk = ~bus_clk;

  // Responder memory: stores bus writes, answers a BUS_RD pulse by driving
  // the addressed byte during the following cycle. Otherwise the bench parks
  // the bus at 0x00 (except while BUS_WR is out), so any stray drive by the
  // master shows up as a non-zero value.
  logic [7:0] mem [0:65535];
  logic       rd_drive = 1'b0;
  logic [7:0] rd_q = 8'h00;
  logic       tb_en;
  logic [7:0] tb_val;

  assign tb_en    = rd_drive | ~bus_wr;
  assign tb_val   = rd_drive ? rd_q : 8'h00;
  assign bus_data = tb_en ? tb_val : 8'hzz;

  // Memory model of the bus slave.
  always @(posedge bus_clk) begin
    if (bus_wr) mem[bus_add] <= bus_data;
    rd_drive <= bus_rd;
    if (bus_rd) rd_q <= mem[bus_add];
  end

  // Bus monitor sampled mid-cycle.
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  logic [15:0] rd_adds [$];
  logic [7:0]  rsp_log [$];

  always @(negedge bus_clk) begin
    if (bus_rd && bus_wr) both_cnt++;
    if (bus_rd) begin
      rd_cnt++;
      rd_adds.push_back(bus_add);
    end
    if (bus_wr) wr_cnt++;
    if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_data);
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer a command and return #1 after the handshake edge.
  task automatic send_cmd(input logic w, input logic [15:0] a, input logic [7:0] d,
                          input logic [7:0] l, input logic keep);
    bit done;
    done = 1'b0;
    cmd_write = w;
    cmd_add   = a;
    cmd_data  = d;
    cmd_len   = l;
    cmd_valid = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      if (cmd_ready) done = 1'b1;
      @(posedge bus_clk);
      #1;
    end
    if (!done) chk("cmd_handshake_timeout", 32'd0, 32'd1);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    send_cmd(1'b1, a, d, 8'd0, 1'b0);
    @(posedge bus_clk);
    #1;
  endtask

  task automatic wait_rsp(input string tag);
    for (int n = 0; n < 20 && !rsp_valid; n++) begin
      @(posedge bus_clk);
      #1;
    end
    chk(tag, rsp_valid, 1'b1);
  endtask

  logic [7:0] exp3 [3];
  int         rd_base;
  int         wr_base;

  initial begin
    exp3[0] = 8'h11; exp3[1] = 8'h22; exp3[2] = 8'h33;
    bus_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_add   = 16'h0;
    cmd_data  = 8'h0;
    cmd_len   = 8'h0;
    rsp_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge bus_clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_rd", bus_rd, 1'b0);
    chk("rst_bus_wr", bus_wr, 1'b0);
    chk("rst_bus_add", bus_add, 16'h0000);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_bus_data", bus_data, 8'h00);
    bus_rst = 1'b0;
    #1;
    chk("idle_cmd_ready", cmd_ready, 1'b1);

    // Single write, 2-cycle command.
    wr_base = wr_cnt;
    send_cmd(1'b1, 16'h0010, 8'hA5, 8'd7, 1'b0);
    chk("wr_bus_wr", bus_wr, 1'b1);
    chk("wr_bus_rd", bus_rd, 1'b0);
    chk("wr_bus_add", bus_add, 16'h0010);
    chk("wr_bus_data", bus_data, 8'hA5);
    chk("wr_cmd_ready", cmd_ready, 1'b0);
    chk("wr_busy", busy, 1'b1);
    @(posedge bus_clk);
    #1;
    chk("wr_done_bus_wr", bus_wr, 1'b0);
    chk("wr_done_cmd_ready", cmd_ready, 1'b1);
    chk("wr_done_bus_add", bus_add, 16'h0000);
    chk("wr_done_bus_data", bus_data, 8'h00);
    repeat (3) @(posedge bus_clk);
    #1;
    chk("wr_pulse_count", wr_cnt - wr_base, 1);

    // Burst read of 3 beats, consumer always ready.
    bus_write(16'h0100, 8'h11);
    bus_write(16'h0101, 8'h22);
    bus_write(16'h0102, 8'h33);
    rsp_ready = 1'b1;
    send_cmd(1'b0, 16'h0100, 8'h00, 8'd2, 1'b0);
    for (int b = 0; b < 3; b++) begin
      chk("rd_bus_rd", bus_rd, 1'b1);
      chk("rd_bus_add", bus_add, 16'h0100 + 16'(b));
      chk("rd_bus_data_undriven", bus_data, 8'h00);
      @(posedge bus_clk);
      #1;
      chk("rdw_bus_rd", bus_rd, 1'b0);
      chk("rdw_bus_add", bus_add, 16'h0100 + 16'(b));
      chk("rdw_rsp_valid", rsp_valid, 1'b0);
      @(posedge bus_clk);
      #1;
      chk("resp_valid", rsp_valid, 1'b1);
      chk("resp_data", rsp_data, exp3[b]);
      @(posedge bus_clk);
      #1;
    end
    chk("burst_end_busy", busy, 1'b0);
    chk("burst_end_cmd_ready", cmd_ready, 1'b1);

    // Same read, beat 2 stalled for 5 cycles.
    rsp_ready = 1'b0;
    rsp_log.delete();
    rd_base = rd_cnt;
    send_cmd(1'b0, 16'h0100, 8'h00, 8'd2, 1'b0);
    for (int b = 0; b < 3; b++) begin
      wait_rsp("stall_rsp_seen");
      chk("stall_rsp_data", rsp_data, exp3[b]);
      if (b == 1) begin
        for (int s = 0; s < 5; s++) begin
          @(posedge bus_clk);
          #1;
          chk("stall_hold_valid", rsp_valid, 1'b1);
          chk("stall_hold_data", rsp_data, 8'h22);
          chk("stall_no_bus_rd", bus_rd, 1'b0);
        end
      end
      rsp_ready = 1'b1;
      @(posedge bus_clk);
      #1;
      rsp_ready = 1'b0;
      chk("stall_ack_drop", rsp_valid, 1'b0);
    end
    chk("stall_rd_count", rd_cnt - rd_base, 3);
    chk("stall_rsp_count", rsp_log.size(), 3);
    if (rsp_log.size() == 3) chk("stall_rsp_beat2", rsp_log[1], 8'h22);
    chk("stall_end_busy", busy, 1'b0);

    // Address wrap 0xFFFF -> 0x0000.
    bus_write(16'hFFFF, 8'h5A);
    bus_write(16'h0000, 8'hC3);
    rd_adds.delete();
    rsp_log.delete();
    rsp_ready = 1'b1;
    send_cmd(1'b0, 16'hFFFF, 8'h00, 8'd1, 1'b0);
    repeat (6) @(posedge bus_clk);
    #1;
    chk("wrap_rd_count", rd_adds.size(), 2);
    chk("wrap_rsp_count", rsp_log.size(), 2);
    if (rd_adds.size() == 2) begin
      chk("wrap_add0", rd_adds[0], 16'hFFFF);
      chk("wrap_add1", rd_adds[1], 16'h0000);
    end
    if (rsp_log.size() == 2) begin
      chk("wrap_data0", rsp_log[0], 8'h5A);
      chk("wrap_data1", rsp_log[1], 8'hC3);
    end
    chk("wrap_end_busy", busy, 1'b0);

    // Reset during RD_WAIT of beat 1 of a 4-beat read.
    send_cmd(1'b0, 16'h0100, 8'h00, 8'd3, 1'b0);
    @(posedge bus_clk);
    #1;
    chk("pre_rst_in_rdwait", busy, 1'b1);
    bus_rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_bus_rd", bus_rd, 1'b0);
    chk("mid_rst_bus_wr", bus_wr, 1'b0);
    chk("mid_rst_bus_add", bus_add, 16'h0000);
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_rsp_data", rsp_data, 8'h00);
    @(posedge bus_clk);
    #1;
    chk("mid_rst_bus_data", bus_data, 8'h00);
    rd_base = rd_cnt;
    @(posedge bus_clk);
    #1;
    bus_rst = 1'b0;
    repeat (4) @(posedge bus_clk);
    #1;
    chk("post_rst_no_reads", rd_cnt - rd_base, 0);
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    send_cmd(1'b1, 16'h0002, 8'h77, 8'd0, 1'b0);
    chk("post_rst_wr", bus_wr, 1'b1);
    chk("post_rst_wr_add", bus_add, 16'h0002);
    chk("post_rst_wr_data", bus_data, 8'h77);
    @(posedge bus_clk);
    #1;
    chk("post_rst_wr_done", cmd_ready, 1'b1);
    send_cmd(1'b0, 16'h0002, 8'h00, 8'd0, 1'b0);
    wait_rsp("post_rst_rd_seen");
    chk("post_rst_rd_data", rsp_data, 8'h77);
    @(posedge bus_clk);
    #1;
    chk("post_rst_rd_idle", busy, 1'b0);

    // Back-to-back write then read with CMD_VALID held high.
    send_cmd(1'b1, 16'h0020, 8'h3C, 8'd0, 1'b1);
    cmd_write = 1'b0;
    cmd_add   = 16'h0010;
    cmd_data  = 8'h0F;
    cmd_len   = 8'd0;
    chk("b2b_wr", bus_wr, 1'b1);
    chk("b2b_wr_ready_low", cmd_ready, 1'b0);
    @(posedge bus_clk);
    #1;
    chk("b2b_not_accepted_in_write", bus_rd, 1'b0);
    chk("b2b_idle_ready", cmd_ready, 1'b1);
    @(posedge bus_clk);
    #1;
    cmd_valid = 1'b0;
    chk("b2b_rd", bus_rd, 1'b1);
    chk("b2b_rd_add", bus_add, 16'h0010);
    chk("b2b_rd_undriven", bus_data, 8'h00);
    @(posedge bus_clk);
    #1;
    chk("b2b_rdw_bus_data", bus_data, 8'hA5);
    @(posedge bus_clk);
    #1;
    chk("b2b_rsp_valid", rsp_valid, 1'b1);
    chk("b2b_rsp_data", rsp_data, 8'hA5);
    @(posedge bus_clk);
    #1;
    chk("b2b_end_busy", busy, 1'b0);
    chk("b2b_idle_stays", busy, 1'b0);
    chk("never_rd_and_wr", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
